// File: rtl/hdr_rd_sequencer.sv
// Header read-pointer sequencer: walks rd_ptr from a latched start index to a
// latched last index (inclusive) over valid/ready, then stops with done or wraps.
module hdr_rd_sequencer #(
  parameter int PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PTR_W-1:0] start_ptr,
  input  logic [PTR_W-1:0] ref_value_mgmt,
  input  logic             wrap_en,
  input  logic             ptr_ready,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             ptr_valid,
  output logic             last_flag,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  state_t           state_q,     state_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0] start_lat_q, start_lat_d;
  logic [PTR_W-1:0] ref_lat_q,   ref_lat_d;
  logic             wrap_lat_q,  wrap_lat_d;
  logic             valid_q,     valid_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;

  logic             at_last_s;
  logic             xfer_s;

  assign at_last_s = (rd_ptr_q == ref_lat_q);
  assign xfer_s    = valid_q && ptr_ready;

  // Next-state, pointer and latch update; abort overrides every other action.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    start_lat_d = start_lat_q;
    ref_lat_d   = ref_lat_q;
    wrap_lat_d  = wrap_lat_q;
    err_d       = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      rd_ptr_d = PTR_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd_ptr_d = PTR_ZERO;
          if (start) begin
            if (start_ptr <= ref_value_mgmt) begin
              state_d     = ST_RUN;
              rd_ptr_d    = start_ptr;
              start_lat_d = start_ptr;
              ref_lat_d   = ref_value_mgmt;
              wrap_lat_d  = wrap_en;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // Compare before increment so a last index of all-ones never rolls over.
          if (xfer_s) begin
            if (!at_last_s) begin
              rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else if (wrap_lat_q) begin
              rd_ptr_d = start_lat_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        ST_DONE: begin
          state_d  = ST_IDLE;
          rd_ptr_d = PTR_ZERO;
        end
        default: begin
          state_d  = ST_IDLE;
          rd_ptr_d = PTR_ZERO;
        end
      endcase
    end

    valid_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State, pointer, latch and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= PTR_ZERO;
      start_lat_q <= PTR_ZERO;
      ref_lat_q   <= PTR_ZERO;
      wrap_lat_q  <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      start_lat_q <= start_lat_d;
      ref_lat_q   <= ref_lat_d;
      wrap_lat_q  <= wrap_lat_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_ptr    = rd_ptr_q;
  assign ptr_valid = valid_q;
  assign last_flag = valid_q && at_last_s;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/hdr_rd_sequencer.md
# hdr_rd_sequencer

Parametrised header read-pointer sequencer for the L2/L3 buffer. It walks a read pointer from a programmed start index to a programmed last index, inclusive, and presents each index to the header-emission logic over a valid/ready handshake. It flags the last word and then either stops with a done pulse or wraps to the start index for repeated emission. Management values are latched at start, so mid-run management writes do not disturb an active sequence.

## Interface
Parameters:
- `PTR_W`, default 6: pointer width; all pointer arithmetic is modulo 2^PTR_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sequence; honoured in IDLE only.
- `abort` in 1: terminate the sequence; honoured in every state.
- `start_ptr` in PTR_W: first index; sampled on an accepted `start`.
- `ref_value_mgmt` in PTR_W: last index, inclusive; sampled on an accepted `start`.
- `wrap_en` in 1: 1 = loop back to the start index after the last index; 0 = stop. Sampled on an accepted `start`.
- `ptr_ready` in 1: consumer accepts the current pointer.
- `rd_ptr` out PTR_W: current read pointer.
- `ptr_valid` out 1: `rd_ptr` is valid for transfer.
- `last_flag` out 1: `ptr_valid && (rd_ptr == ref_lat)`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse marking a non-wrapping sequence completed.
- `err` out 1: one-cycle pulse marking a rejected start (`start_ptr > ref_value_mgmt`).

## Operation
- Internal latches `start_lat`, `ref_lat` and `wrap_lat` are loaded on an accepted start.
- An accepted start is `start && !abort && state==IDLE && start_ptr <= ref_value_mgmt`.
- The state machine has three states: IDLE, RUN, DONE.
- IDLE:
  - `rd_ptr` = 0 and `ptr_valid` = 0.
  - Accepted start: go to RUN and set `rd_ptr <= start_ptr`.
  - `start` with `start_ptr > ref_value_mgmt`: stay in IDLE, pulse `err` the next cycle, leave the latches unchanged.
- RUN:
  - `ptr_valid` = 1.
  - A transfer is `ptr_valid && ptr_ready`.
  - Transfer with `rd_ptr != ref_lat`: `rd_ptr <= rd_ptr + 1`.
  - Transfer with `rd_ptr == ref_lat` and `wrap_lat` = 1: `rd_ptr <= start_lat`, stay in RUN.
  - Transfer with `rd_ptr == ref_lat` and `wrap_lat` = 0: go to DONE.
  - No transfer: `rd_ptr` holds.
- DONE:
  - `ptr_valid` = 0 and `done` = 1 for exactly one cycle.
  - Unconditionally go to IDLE with `rd_ptr <= 0`.
- Abort:
  - From any state, go to IDLE with `rd_ptr <= 0`.
  - No `done` and no `err` are produced.
  - Abort has priority over transfer and over start.
- Start outside IDLE is ignored, including during DONE.
- Boundary cases:
  - `start_ptr == ref_value_mgmt`: single-word sequence; `last_flag` is high on the first valid cycle.
  - `ref_lat == 2^PTR_W-1`: the increment never wraps, because the compare precedes the increment.
  - `ref_value_mgmt` or `start_ptr` changing during RUN has no effect.
- Reset values:
  - State = IDLE.
  - `rd_ptr` = 0.
  - `ptr_valid`, `last_flag`, `busy`, `done`, `err` = 0.
  - Latches = 0.

## Timing
- `done`, `err` and `ptr_valid` are registered (state-decoded); `last_flag` and `busy` are combinational from registers only.
- There is no combinational path from `ptr_ready` to any output.
- Start latency: `start` sampled at edge N gives `ptr_valid` = 1 and `rd_ptr` = `start_ptr` after edge N, for the full cycle N+1.
- Throughput: one pointer per cycle with `ptr_ready` held at 1.
- Non-wrapping run timing:
  - L = `ref - start + 1` words.
  - With `ptr_ready` held at 1, `ptr_valid` is high for L cycles.
  - `done` is high on the cycle after the last transfer.
  - `busy` returns to 0 one cycle after that.
- Back-to-back start: `start` is honoured from the first IDLE cycle after DONE. Minimum gap is 2 cycles between the final transfer and the next valid pointer.
- `rst` or `abort` asserted at edge N: outputs reach their IDLE values after edge N.

## Test plan
- Basic run: `rst` then start with start_ptr=3, ref=7, wrap_en=0, `ptr_ready`=1 -> `rd_ptr` 3,4,5,6,7 on consecutive cycles; `last_flag` only at 7; `done` pulse on the next cycle; then IDLE with `rd_ptr`=0.
- Backpressure: same run with `ptr_ready` toggled 1,0,0,1,... -> `rd_ptr` holds while ready=0; exactly 5 transfers; the sequence of transferred values is unchanged.
- Wrap mode: start_ptr=2, ref=4, wrap_en=1, ready=1 for 10 cycles -> 2,3,4,2,3,4,2,3,4,2; no `done`; then abort -> IDLE next cycle with no `done`.
- Edges: start_ptr=ref=63 with PTR_W=6 -> one valid cycle with `last_flag`=1, then `done`. start_ptr=10, ref=5 -> `err` pulse; `busy` stays 0.
- Mid-run disturbance: during RUN, change `ref_value_mgmt` and pulse `start` -> no effect on the sequence. Assert `start`+`abort` together in IDLE -> stays IDLE.
- Reset mid-operation: assert `rst` while RUN with `rd_ptr`=5 -> next cycle `rd_ptr`=0; `ptr_valid`, `busy`, `done` = 0.
